// File: rtl/booth_issue_ctrl_if.sv
// booth_issue_ctrl_if
//   Bundles the operand handshake, the multiplier drive/return signals and
//   the result handshake of booth_issue_ctrl.
//   master : controller view (drives op_ready, mul_*, res_valid, res_product, busy)
//   slave  : environment view (drives op_valid, op_a, op_b, mul_product, res_ready)
interface booth_issue_ctrl_if #(
    parameter int Width_inputs  = 16,
    parameter int Width_product = 32
);
    logic                     op_valid;
    logic                     op_ready;
    logic [Width_inputs-1:0]  op_a;
    logic [Width_inputs-1:0]  op_b;
    logic [Width_inputs-1:0]  mul_a;
    logic [Width_inputs-1:0]  mul_b;
    logic                     mul_ld;
    logic                     mul_ld_pp;
    logic [Width_product-1:0] mul_product;
    logic                     res_valid;
    logic                     res_ready;
    logic [Width_product-1:0] res_product;
    logic                     busy;

    modport master (
        input  op_valid, op_a, op_b, mul_product, res_ready,
        output op_ready, mul_a, mul_b, mul_ld, mul_ld_pp, res_valid, res_product, busy
    );

    modport slave (
        output op_valid, op_a, op_b, mul_product, res_ready,
        input  op_ready, mul_a, mul_b, mul_ld, mul_ld_pp, res_valid, res_product, busy
    );
endinterface

// File: rtl/booth_issue_ctrl.sv
// booth_issue_ctrl
//   Issues one operand pair at a time to a fixed-latency sequential Booth
//   multiplier, waits out its latency, and holds the product until the
//   consumer takes it.
//   Ports:
//     clk   - sole clock, rising edge
//     reset - asynchronous, active-high
//     bus   - booth_issue_ctrl_if.master: op_valid/op_ready/op_a/op_b,
//             mul_a/mul_b/mul_ld/mul_ld_pp/mul_product,
//             res_valid/res_ready/res_product, busy
//   Optional feature: define BOOTH_ISSUE_ZERO_BYPASS_EN to short-circuit
//   operations with a zero operand straight to HOLD with a zero product.
module booth_issue_ctrl #(
    parameter int Width_inputs  = 16,
    parameter int Width_product = 32,
    parameter int Latency       = 17
) (
    input  logic                clk,
    input  logic                reset,
    booth_issue_ctrl_if.master  bus
);

    if (Width_product != 2 * Width_inputs) begin : g_width_check
        $error("Width_product must equal 2*Width_inputs");
    end

    localparam int CntW = (Latency > 1) ? $clog2(Latency) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(Latency - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_HOLD
    } state_e;

    state_e                   state_q, state_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [Width_inputs-1:0]  a_q, a_d;
    logic [Width_inputs-1:0]  b_q, b_d;
    logic [Width_product-1:0] prod_q, prod_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        unique case (state_q)
            ST_IDLE: begin
                // op_ready is high only here, so op_valid alone marks an accept
                if (bus.op_valid) begin
                    a_d = bus.op_a;
                    b_d = bus.op_b;
`ifdef BOOTH_ISSUE_ZERO_BYPASS_EN
                    if ((bus.op_a == '0) || (bus.op_b == '0)) begin
                        prod_d  = '0;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_LOAD;
                    end
`else
                    state_d = ST_LOAD;
`endif
                end
            end
            ST_LOAD: begin
                // counter runs Latency-1 .. 0, giving Latency cycles in WAIT
                cnt_d   = CntLoad;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    prod_d  = bus.mul_product;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.op_ready    = (state_q == ST_IDLE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.mul_ld      = (state_q == ST_LOAD);
    assign bus.mul_ld_pp   = (state_q == ST_LOAD);
    assign bus.res_valid   = (state_q == ST_HOLD);
    assign bus.mul_a       = a_q;
    assign bus.mul_b       = b_q;
    assign bus.res_product = prod_q;

endmodule

// File: tb/tb_booth_issue_ctrl.sv
module tb_booth_issue_ctrl;

    localparam int WI  = 16;
    localparam int WP  = 32;
    localparam int LAT = 17;

    logic clk;
    logic reset;

    int n_chk;
    int n_fail;

    booth_issue_ctrl_if #(.Width_inputs(WI), .Width_product(WP)) bus ();

    booth_issue_ctrl #(
        .Width_inputs (WI),
        .Width_product(WP),
        .Latency      (LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier stand-in: product only becomes correct Latency-1 cycles
    // after the load strobe; before that it shows a junk pattern.
    logic [WP-1:0] m_pend;
    int            m_cnt;
    initial begin
        m_pend = '0;
        m_cnt  = 0;
    end
    always @(posedge clk) begin
        if (bus.mul_ld) begin
            m_pend <= WP'($signed(bus.mul_a) * $signed(bus.mul_b));
            m_cnt  <= LAT - 1;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
    end
    assign bus.mul_product = (m_cnt == 0) ? m_pend : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One operation: offer a/b, count strobes, measure latency from the
    // accept edge, stall the result for 'stall' cycles, then hand it off.
    // While in HOLD the next operand pair (nxt_*) may be offered.
    task automatic run_op(input logic [WI-1:0] a, input logic [WI-1:0] b, input int stall,
                          input logic [WP-1:0] exp_p, input int exp_lat, input int exp_ld,
                          input bit nxt_v, input logic [WI-1:0] nxt_a, input logic [WI-1:0] nxt_b);
        int t, w, lat, ldc, ldppc, viol;
        logic [WP-1:0] p0;
        bus.op_valid  = 1'b1;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.res_ready = (stall == 0);
        w = 0;
        while (!bus.op_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", 64'(w), 64'd0);
        if (!bus.op_ready) begin
            bus.op_valid = 1'b0;
            return;
        end
        @(negedge clk);
        t = 1; lat = -1; ldc = 0; ldppc = 0; viol = 0;
        bus.op_valid = 1'b0;
        while (t < 60) begin
            if (bus.mul_ld) ldc++;
            if (bus.mul_ld_pp) ldppc++;
            if (bus.res_valid) begin
                lat = t;
                break;
            end
            if (!bus.busy || bus.op_ready) viol++;
            // noise on the operand side while busy
            bus.op_valid = t[0];
            bus.op_a     = ~a;
            bus.op_b     = b ^ 16'h5A5A;
            @(negedge clk);
            t++;
        end
        bus.op_valid = nxt_v;
        bus.op_a     = nxt_a;
        bus.op_b     = nxt_b;
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("mul_ld_count", 64'(ldc), 64'(exp_ld));
        chk("mul_ld_pp_count", 64'(ldppc), 64'(exp_ld));
        chk("busy_while_pending", 64'(viol), 64'd0);
        chk("res_product", 64'(bus.res_product), 64'(exp_p));
        chk("mul_a_held", 64'(bus.mul_a), 64'(a));
        chk("mul_b_held", 64'(bus.mul_b), 64'(b));
        if (lat < 0) return;
        p0 = bus.res_product;
        viol = 0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!bus.res_valid || bus.res_product !== p0 || bus.op_ready) viol++;
        end
        chk("hold_stable", 64'(viol), 64'd0);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("op_ready_after_hs", 64'(bus.op_ready), 64'd1);
        chk("res_valid_after_hs", 64'(bus.res_valid), 64'd0);
        chk("mul_a_after_hs", 64'(bus.mul_a), 64'(a));
    endtask

    typedef struct {
        logic [WI-1:0] a;
        logic [WI-1:0] b;
        int            stall;
        logic [WP-1:0] p;
        int            lat;
        int            ld;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int rv;
        n_chk  = 0;
        n_fail = 0;

        vecs[0] = '{16'h0003, 16'h0005, 0, 32'h0000_000F, 19, 1};
        vecs[1] = '{16'hFFFE, 16'h0007, 0, 32'hFFFF_FFF2, 19, 1};
        vecs[2] = '{16'h8000, 16'h8000, 0, 32'h4000_0000, 19, 1};
        vecs[3] = '{16'h7FFF, 16'h7FFF, 1, 32'h3FFF_0001, 19, 1};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 0, 32'h0000_0001, 19, 1};
        vecs[5] = '{16'h8000, 16'h0001, 2, 32'hFFFF_8000, 19, 1};
        vecs[6] = '{16'h0010, 16'hFFF0, 3, 32'hFFFF_FF00, 19, 1};
`ifdef BOOTH_ISSUE_ZERO_BYPASS_EN
        vecs[7] = '{16'h0000, 16'h1234, 0, 32'h0000_0000, 1, 0};
`else
        vecs[7] = '{16'h0000, 16'h1234, 0, 32'h0000_0000, 19, 1};
`endif

        bus.op_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.res_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_op_ready", 64'(bus.op_ready), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_res_product", 64'(bus.res_product), 64'd0);
        chk("rst_mul_ld", 64'({bus.mul_ld, bus.mul_ld_pp}), 64'd0);
        chk("rst_mul_ab", 64'({bus.mul_a, bus.mul_b}), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].stall, vecs[i].p, vecs[i].lat, vecs[i].ld,
                   1'b0, '0, '0);
        end

        // Stalled result with the next pair already offered: it must be
        // taken on the edge right after the handshake.
        run_op(16'h0003, 16'h0005, 5, 32'h0000_000F, 19, 1, 1'b1, 16'h0006, 16'h0007);
        run_op(16'h0006, 16'h0007, 0, 32'h0000_002A, 19, 1, 1'b0, '0, '0);

        // Reset in the middle of WAIT abandons the operation.
        bus.op_valid = 1'b1;
        bus.op_a     = 16'h0009;
        bus.op_b     = 16'h0009;
        @(negedge clk);
        bus.op_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", 64'(bus.busy), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_op_ready", 64'(bus.op_ready), 64'd1);
        chk("mid_rst_mul_ab", 64'({bus.mul_a, bus.mul_b}), 64'd0);
        chk("mid_rst_res_product", 64'(bus.res_product), 64'd0);
        chk("mid_rst_mul_ld", 64'({bus.mul_ld, bus.mul_ld_pp}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        rv = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.res_valid || bus.busy) rv++;
        end
        chk("no_stale_result", 64'(rv), 64'd0);
        run_op(16'h0002, 16'h0004, 0, 32'h0000_0008, 19, 1, 1'b0, '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/booth_issue_ctrl.md
BOOTH_ISSUE_CTRL -- requirements
Module: booth_issue_ctrl

Interface
REQ-001 SHALL have parameter Width_inputs, default 16, operand width.
REQ-002 SHALL have parameter Width_product, default 32, product width; SHALL equal 2*Width_inputs.
REQ-003 SHALL have parameter Latency, default 17, cycles from the mul_ld pulse until mul_product is stable.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port op_valid  input  1  operand pair offered.
REQ-007 SHALL have port op_ready  output  1  block accepts operand pair.
REQ-008 SHALL have port op_a  input  Width_inputs  multiplicand, two's complement.
REQ-009 SHALL have port op_b  input  Width_inputs  multiplier, two's complement.
REQ-010 SHALL have port mul_a  output  Width_inputs  multiplicand to multiplier in_A.
REQ-011 SHALL have port mul_b  output  Width_inputs  multiplier to multiplier in_B.
REQ-012 SHALL have port mul_ld  output  1  operand load strobe to multiplier ld.
REQ-013 SHALL have port mul_ld_pp  output  1  partial-product load strobe to multiplier ld_PP.
REQ-014 SHALL have port mul_product  input  Width_product  product from multiplier.
REQ-015 SHALL have port res_valid  output  1  result available.
REQ-016 SHALL have port res_ready  input  1  consumer accepts result.
REQ-017 SHALL have port res_product  output  Width_product  registered result.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, WAIT, HOLD; one operation in flight at a time.
REQ-020 SHALL drive op_ready=1 only in IDLE; accept occurs on an edge where op_valid&&op_ready; op_a/op_b SHALL be ignored otherwise.
REQ-021 On accept, SHALL latch op_a/op_b into internal registers driving mul_a/mul_b and go IDLE->LOAD; mul_a/mul_b SHALL hold these values until the next accept.
REQ-022 In LOAD (exactly one cycle), SHALL drive mul_ld=1 and mul_ld_pp=1; both SHALL be 0 in all other states.
REQ-023 LOAD->WAIT SHALL load a down-counter with Latency-1; WAIT SHALL last exactly Latency cycles, leaving when the counter is 0.
REQ-024 On the WAIT exit edge, SHALL register mul_product into res_product and go WAIT->HOLD.
REQ-025 res_valid SHALL be 1 exactly in HOLD; first res_valid cycle SHALL be Latency+2 cycles after the accept edge (19 at default).
REQ-026 In HOLD, res_product SHALL remain stable until res_valid&&res_ready; that edge SHALL go HOLD->IDLE.
REQ-027 The next accept SHALL occur no earlier than the cycle after the result handshake; no overlap, no result loss under any res_ready pattern.
REQ-028 res_product SHALL be passed through unmodified; no sign extension, rounding or saturation.
REQ-029 op_valid toggling while busy SHALL not affect state, counter or outputs.

Reset
REQ-030 Reset SHALL immediately force IDLE, counter 0, mul_ld=0, mul_ld_pp=0, res_valid=0, res_product=0, mul_a=0, mul_b=0, busy=0, op_ready=1 after deassertion.
REQ-031 Reset in LOAD, WAIT or HOLD SHALL discard the in-flight operation with no later res_valid for it.

Configuration
REQ-032 Macro BOOTH_ISSUE_ZERO_BYPASS_EN, when defined, SHALL make an accept with op_a==0 or op_b==0 go IDLE->HOLD directly with res_product=0, no mul_ld/mul_ld_pp pulse, res_valid in the cycle after accept.
REQ-033 Without BOOTH_ISSUE_ZERO_BYPASS_EN, zero operands SHALL take the normal LOAD/WAIT path with full Latency+2 timing.

Verification
REQ-034 Accept op_a=3, op_b=5, res_ready=1 -> one mul_ld pulse in cycle 1; res_valid cycle 19 with res_product=0x0000000F; op_ready high cycle 20.
REQ-035 op_a=0xFFFE (-2), op_b=7 -> res_product=0xFFFFFFF2; op_a=op_b=0x8000 -> res_product=0x40000000.
REQ-036 res_ready low 5 cycles after res_valid, second op_valid pending -> res_product stable, op_ready=0 throughout; second op accepted cycle after handshake.
REQ-037 op_a=0, op_b=0x1234: with macro -> res_valid cycle 1, res_product=0, no mul_ld; without -> res_valid cycle 19, res_product=0.
REQ-038 Reset asserted in WAIT cycle 10 -> all outputs at reset values immediately; no res_valid until a new accept; new op 2*4 returns 8 at Latency+2.
